// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the nibble-serial multiword adder: FSM state encoding
// and the width of one adder slice.
package multiword_add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carrylook_4bit.sv
// 4-bit carry-lookahead adder used as the single shared slice adder.
module carrylook_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // All carries are formed directly from generate/propagate terms and carry-in.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential add/subtract of two W-bit operands, one 4-bit slice per cycle,
// LSB first, on a single shared carry-lookahead slice adder.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SLICE_W*NIBBLES-1:0]   a,
    input  logic [SLICE_W*NIBBLES-1:0]   b,
    input  logic                         sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE_W*NIBBLES-1:0]   sum,
    output logic                         cout,
    output logic                         ovf
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               co_sl;
    logic               last_sl;

    assign a_sl    = a_q[SLICE_W*idx_q +: SLICE_W];
    assign b_sl    = b_q[SLICE_W*idx_q +: SLICE_W];
    assign last_sl = (idx_q == IDX_W'(NIBBLES - 1));

    carrylook_4bit u_slice_add (
        .a_i (a_sl),
        .b_i (b_sl),
        .c_i (carry_q),
        .s_o (s_sl),
        .c_o (co_sl)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        // clr wins over both handshakes and freezes the result registers.
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b ^ {W{sub}};
                        carry_d = sub;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    sum_d[SLICE_W*idx_q +: SLICE_W] = s_sl;
                    carry_d = co_sl;
                    idx_d   = idx_q + 1'b1;
                    if (last_sl) begin
                        cout_d  = co_sl;
                        ovf_d   = (a_q[W-1] == b_q[W-1]) & (s_sl[SLICE_W-1] != a_q[W-1]);
                        idx_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with NIBBLES=4 (16-bit operands).
module tb_multiword_add_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    multiword_add_seq #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request on the next edge, then scramble the operand inputs.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
        a        = va;
        b        = vb;
        sub      = vs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
    endtask

    // Count edges after acceptance until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
        send(v.a, v.b, v.sub);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(NIB));
        chk({tag, "_sum"}, 32'(sum), 32'(v.exp_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(v.exp_cout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
        consume();
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;
        int seen;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Consumer stalls for three cycles in DONE.
        send(16'h1234, 16'h0FCD, 1'b0);
        wait_done(lat);
        chk("hold_latency", 32'(lat), 32'(NIB));
        held = sum;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_sum", i), 32'(sum), 32'(held));
            chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        chk("hold_sum_value", 32'(sum), 32'h2201);
        out_ready = 1'b1;
        #1;
        chk("hs_cycle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset while slice 2 is being added.
        send(16'h7FFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrun_rst_no_out_valid", 32'(seen), 32'd0);
        run_vec(vecs[0], "after_rst");

        // clr with a concurrent request in IDLE must not accept it.
        clr      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        sub      = 1'b0;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_idle_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("clr_idle_no_out_valid", 32'(seen), 32'd0);

        // clr mid-RUN drops the operation.
        send(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_run_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("clr_run_no_out_valid", 32'(seen), 32'd0);
        run_vec(vecs[4], "after_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
